// File: rtl/tune_led_bar.sv
// Tuning-indicator LED driver: filters the tuner's deviation codes and
// drives a pair or centre-out bar pattern. The pattern blinks when on
// pitch and blanks after the tuner stops reporting.
module tune_led_bar #(
  parameter int LED_W       = 8,
  parameter int CODE_W      = 4,
  parameter int HOLD_N      = 3,
  parameter int BLINK_HALF  = 25_000_000,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] tone,
  input  logic              tone_valid,
  input  logic              mode,
  input  logic              blink_en,
  output logic [LED_W-1:0]  led,
  output logic              locked
);

  localparam int CNT_W  = $clog2(HOLD_N + 1);
  localparam int PH_W   = $clog2(BLINK_HALF + 1);
  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [CODE_W-1:0] C_CODE    = CODE_W'(LED_W / 2);
  localparam logic [CODE_W:0]   LED_W_CMP = (CODE_W + 1)'(LED_W);
  localparam logic [CNT_W-1:0]  HOLD_C    = CNT_W'(HOLD_N);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BLINK_HALF - 1);
  // With the timeout disabled the idle counter still saturates but never blanks.
  localparam logic [IDLE_W-1:0] IDLE_MAX  = (TIMEOUT_CYC > 0) ? IDLE_W'(TIMEOUT_CYC) : IDLE_W'(1);

  logic [CODE_W-1:0] r_cand, r_commit;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic [PH_W-1:0]   r_pcnt;
  logic              r_phase;

  logic [CODE_W-1:0] w_code, w_cand_nx, w_commit_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [IDLE_W-1:0] w_idle_nx;
  logic [LED_W-1:0]  w_pat;
  logic              w_on_pitch;

  // Out-of-range codes are folded to "no note".
  assign w_code     = ({1'b0, tone} >= LED_W_CMP) ? '0 : tone;
  assign w_on_pitch = (r_commit == C_CODE);

  // Stability filter and timeout: next-state for cand/cnt/commit/idle.
  always_comb begin
    w_cand_nx   = r_cand;
    w_cnt_nx    = r_cnt;
    w_commit_nx = r_commit;
    w_idle_nx   = r_idle;
    if (tone_valid) begin
      w_idle_nx = '0;
      if (w_code == r_cand) begin
        if (r_cnt != HOLD_C) w_cnt_nx = r_cnt + CNT_ONE;
      end else begin
        w_cand_nx = w_code;
        w_cnt_nx  = CNT_ONE;
      end
      if (w_cnt_nx == HOLD_C) w_commit_nx = w_cand_nx;
    end else begin
      if (r_idle != IDLE_MAX) w_idle_nx = r_idle + IDLE_W'(1);
      if ((TIMEOUT_CYC != 0) && (w_idle_nx == IDLE_MAX)) begin
        w_cand_nx   = '0;
        w_cnt_nx    = '0;
        w_commit_nx = '0;
      end
    end
  end

  // Pattern for the committed code: pair covers bits LED_W-c and LED_W-c-1;
  // bar covers the contiguous span of all pairs between c and the centre.
  always_comb begin
    int c, lo, hi;
    w_pat = '0;
    c     = int'(r_commit);
    lo    = (c < LED_W / 2) ? c : LED_W / 2;
    hi    = (c < LED_W / 2) ? LED_W / 2 : c;
    if (c != 0) begin
      for (int b = 0; b < LED_W; b++) begin
        if (mode) begin
          if ((b >= LED_W - 1 - hi) && (b <= LED_W - lo)) w_pat[b] = 1'b1;
        end else begin
          if ((b == LED_W - c) || (b == LED_W - c - 1)) w_pat[b] = 1'b1;
        end
      end
    end
  end

  // Filter, timeout and commit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_commit <= '0;
      r_idle   <= '0;
    end else begin
      r_cand   <= w_cand_nx;
      r_cnt    <= w_cnt_nx;
      r_commit <= w_commit_nx;
      r_idle   <= w_idle_nx;
    end
  end

  // Blink phase: free-runs only while on pitch, restarts "on" otherwise.
  always_ff @(posedge clk) begin
    if (rst || !w_on_pitch) begin
      r_pcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_pcnt == PH_LAST) begin
      r_pcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_pcnt  <= r_pcnt + PH_W'(1);
    end
  end

  // Registered outputs; blink gating applies only when on pitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= '0;
      locked <= 1'b0;
    end else begin
      led    <= (blink_en && w_on_pitch && !r_phase) ? '0 : w_pat;
      locked <= w_on_pitch;
    end
  end

endmodule

// File: tb/tb_tune_led_bar.sv
// Bench for tune_led_bar: directed scenarios then randomized traffic, with
// two instances (HOLD_N=3 and HOLD_N=1) checked against a reference model.
module tb_tune_led_bar;

  localparam int LW = 8;
  localparam int CC = LW / 2;
  localparam int BH = 4;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tone = '0;
  logic       tone_valid = 1'b0;
  logic       mode = 1'b0;
  logic       blink_en = 1'b0;
  logic [7:0] led3, led1;
  logic       locked3, locked1;

  int n_tests = 0;
  int n_fail  = 0;

  tune_led_bar #(.LED_W(LW), .CODE_W(4), .HOLD_N(3), .BLINK_HALF(BH), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst(rst), .tone(tone), .tone_valid(tone_valid), .mode(mode),
    .blink_en(blink_en), .led(led3), .locked(locked3));

  tune_led_bar #(.LED_W(LW), .CODE_W(4), .HOLD_N(1), .BLINK_HALF(BH), .TIMEOUT_CYC(TO)) u_dut1 (
    .clk(clk), .rst(rst), .tone(tone), .tone_valid(tone_valid), .mode(mode),
    .blink_en(blink_en), .led(led1), .locked(locked1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history of valid codes, elapsed cycles since the last
  // valid sample, and time spent on pitch.
  int m_hold[2] = '{3, 1};
  int m_commit[2], m_idle[2], m_age[2], m_hn[2];
  int m_hist[2][0:3];
  logic [7:0] exp_led[2];
  logic       exp_lock[2];

  function automatic logic [7:0] pair_pat(input int c);
    logic [7:0] p = '0;
    if (c != 0) begin
      p[LW - c]     = 1'b1;
      p[LW - c - 1] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [7:0] bar_pat(input int c);
    logic [7:0] p = '0;
    int lo, hi;
    if (c == 0) return p;
    lo = (c < CC) ? c : CC;
    hi = (c < CC) ? CC : c;
    for (int k = lo; k <= hi; k++) p = p | pair_pat(k);
    return p;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        exp_led[i] = '0; exp_lock[i] = 1'b0;
        m_commit[i] = 0; m_idle[i] = 0; m_age[i] = 0; m_hn[i] = 0;
      end else begin
        logic [7:0] pat;
        bit all_eq;
        int code;
        pat = mode ? bar_pat(m_commit[i]) : pair_pat(m_commit[i]);
        if (m_commit[i] == CC && blink_en && ((m_age[i] / BH) % 2 == 1)) exp_led[i] = '0;
        else exp_led[i] = pat;
        exp_lock[i] = (m_commit[i] == CC);
        if (m_commit[i] == CC) m_age[i]++; else m_age[i] = 0;
        if (tone_valid) begin
          code = (int'(tone) >= LW) ? 0 : int'(tone);
          m_idle[i] = 0;
          if (m_hn[i] < m_hold[i]) begin
            m_hist[i][m_hn[i]] = code;
            m_hn[i]++;
          end else begin
            for (int k = 0; k < m_hold[i] - 1; k++) m_hist[i][k] = m_hist[i][k + 1];
            m_hist[i][m_hold[i] - 1] = code;
          end
          all_eq = (m_hn[i] == m_hold[i]);
          for (int k = 0; k < m_hn[i]; k++) if (m_hist[i][k] != code) all_eq = 0;
          if (all_eq) m_commit[i] = code;
        end else begin
          m_idle[i]++;
          if (m_idle[i] >= TO) begin
            m_hn[i] = 0;
            m_commit[i] = 0;
          end
        end
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare #1 later.
  task automatic cyc(input logic r, input logic [3:0] t, input logic v,
                     input logic md, input logic be);
    rst = r; tone = t; tone_valid = v; mode = md; blink_en = be;
    @(posedge clk);
    model_step();
    #1;
    chk("led_h3", led3, exp_led[0]);
    chk("lock_h3", locked3, exp_lock[0]);
    chk("led_h1", led1, exp_led[1]);
    chk("lock_h1", locked1, exp_lock[1]);
  endtask

  logic [7:0] blink_seq [10] = '{8'h18, 8'h18, 8'h18, 8'h18, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'h18, 8'h18};

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0);
    chk("reset_led", led3, 8'h00);
    chk("reset_lock", locked3, 1'b0);

    // Pair mode: three samples of code 1
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 0);
      chk("pair_pre", led3, 8'h00);
    end
    cyc(0, 0, 0, 0, 0);
    chk("pair_c1", led3, 8'hC0);

    // Filter restart: 2,2,5,5,5
    cyc(0, 2, 1, 0, 0); chk("restart_hold", led3, 8'hC0);
    cyc(0, 2, 1, 0, 0); chk("restart_hold", led3, 8'hC0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 5, 1, 0, 0); chk("restart_hold", led3, 8'hC0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("restart_c5", led3, 8'h0C);

    // Bar mode
    for (int i = 0; i < 3; i++) cyc(0, 2, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk("bar_c2", led3, 8'h78);
    for (int i = 0; i < 3; i++) cyc(0, 7, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk("bar_c7", led3, 8'h1F);
    cyc(0, 0, 0, 0, 0); chk("mode_toggle", led3, 8'h03);

    // On-pitch blink
    for (int i = 0; i < 3; i++) cyc(0, 4, 1, 0, 1);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 4, 1, 0, 1);
      chk("blink_seq", led3, blink_seq[j]);
      chk("blink_lock", locked3, 1'b1);
    end
    cyc(0, 4, 1, 0, 0); chk("steady", led3, 8'h18);
    cyc(0, 4, 1, 0, 0); chk("steady", led3, 8'h18);

    // Timeout blanking
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); chk("to_before", led3, 8'h18);
    cyc(0, 0, 0, 0, 0); chk("to_blank", led3, 8'h00);
    chk("to_lock", locked3, 1'b0);

    // Valid sample on the timeout cycle
    for (int i = 0; i < 3; i++) cyc(0, 4, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 4, 1, 0, 0);
    cyc(0, 0, 0, 0, 0); chk("to_saved", led3, 8'h18);
    cyc(0, 0, 0, 0, 0); chk("to_saved", led3, 8'h18);

    // Out-of-range on HOLD_N=1
    cyc(0, 9, 1, 0, 0);
    cyc(0, 0, 0, 0, 0); chk("oor_h1", led1, 8'h00);

    // Reset mid-blink
    for (int i = 0; i < 5; i++) cyc(0, 4, 1, 0, 1);
    cyc(1, 4, 1, 0, 1);
    chk("rst_mid_led", led3, 8'h00);
    chk("rst_mid_lock", locked3, 1'b0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_cleared", led3, 8'h00);

    // Randomized traffic
    begin
      logic [3:0] last_t = 4'd4;
      logic md = 1'b0, be = 1'b1;
      int gap = 0;
      for (int n = 0; n < 3000; n++) begin
        logic [3:0] t;
        logic v, r;
        r = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 99) == 0) md = ~md;
        if ($urandom_range(0, 79) == 0) be = ~be;
        if (gap > 0) begin
          gap--; v = 1'b0;
        end else begin
          if ($urandom_range(0, 59) == 0) gap = $urandom_range(5, 14);
          v = ($urandom_range(0, 2) != 0);
        end
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: t = last_t;
          5, 6:          t = 4'd4;
          default:       t = 4'($urandom_range(0, 15));
        endcase
        last_t = t;
        cyc(r, t, v, md, be);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tune_led_bar.md
# tune_led_bar

Parametrised, registered tuning-indicator driver that converts a stream of pitch-deviation codes from the tuner core into an LED pattern. It generalises the fixed 8-LED pair display to any even LED count. It adds four behaviours: a stability filter, a centre-out bar mode, a blinking on-pitch indication, and a blank-on-timeout when the tuner stops reporting. It sits between the pitch classifier and the board LED pins.

## Interface
- LED_W, 8: number of LEDs; even, >= 4.
- CODE_W, 4: width of deviation code; 2^CODE_W >= LED_W.
- HOLD_N, 3: consecutive identical valid samples required before the display changes; >= 1 (1 = no filtering).
- BLINK_HALF, 25_000_000: cycles per on/off half-period of the on-pitch blink; >= 1.
- TIMEOUT_CYC, 100_000_000: cycles without tone_valid before the display blanks; 0 disables the timeout.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- tone  in  CODE_W  deviation code; 0 = no note; 1..LED_W-1 = position; C = LED_W/2 = on pitch.
- tone_valid  in  1  one-cycle qualifier for tone.
- mode  in  1  0 = pair display, 1 = bar display.
- blink_en  in  1  1 = blink when on pitch.
- led  out  LED_W  LED drive, active-high, MSB = flattest.
- locked  out  1  committed code == C.

## Operation
- **Range check.** A sampled code >= LED_W is treated as code 0.
- **Stability filter.** Registers: `cand` (CODE_W bits), `cnt` (saturating at HOLD_N), `commit` (CODE_W bits).
  - On tone_valid with a code equal to `cand`: increment `cnt`.
  - On tone_valid with a code different from `cand`: load `cand` with the code and set `cnt` = 1.
  - When `cnt` reaches HOLD_N, on that same edge, `commit` <= `cand`.
  - Further matching samples keep `commit` unchanged.
- **Pair pattern for code c (1..LED_W-1).** Bits LED_W-c and LED_W-c-1 are set. Code 0 gives all zeros.
  - Example for LED_W=8: c=1 -> 8'b1100_0000; c=4 -> 8'b0001_1000; c=7 -> 8'b0000_0011.
- **Bar pattern.** The OR of the pair patterns for every code between c and C inclusive.
  - Example for LED_W=8: c=2 -> 8'b0111_1000; c=6 -> 8'b0001_1110; c=C -> same as the pair pattern.
- **Blink.** A phase counter counts 0..BLINK_HALF-1, then toggles a `phase` bit.
  - Both the counter and `phase` (to "on") are cleared on any cycle where `commit` != C.
  - When `commit` == C and blink_en = 1, led = pattern while phase is on, else 0.
  - With blink_en = 0 the pattern is shown steadily.
- **Timeout.** `idle` counts cycles since the last tone_valid and saturates.
  - When `idle` reaches TIMEOUT_CYC (with TIMEOUT_CYC != 0): `commit` <= 0, `cand` <= 0, `cnt` <= 0.
  - tone_valid on the same cycle takes priority: `idle` is cleared and the filter updates normally.
- **Output update.** led is recomputed every cycle from `commit`, mode, blink_en and `phase`. A mode or blink_en change therefore shows one cycle later, with no filter restart.
- **locked.** Registered; equals (`commit` == C), unaffected by blink phase.

## Timing
- Reset (synchronous): led = 0, locked = 0, `commit` = `cand` = 0, `cnt` = 0, `idle` = 0, `phase` = on, phase counter = 0.
  - Reset asserted mid-operation overrides every other event on that edge.
- Latency: the HOLD_N-th matching sample is taken at edge k, `commit` updates at edge k, and led/locked reflect it at edge k+1.
- HOLD_N = 1: led follows each valid sample one cycle after its sample edge.
- Samples with tone_valid = 0 neither reset nor advance `cnt`; non-consecutive matching samples still accumulate.
- Blink: the first off-phase starts BLINK_HALF cycles after `commit` becomes C; the period is 2·BLINK_HALF.
- Timeout blanking: led = 0 at TIMEOUT_CYC+1 cycles after the last valid sample. A new note then needs HOLD_N fresh matching samples.

## Test plan
- **Reset and pair mode.** Reset, then LED_W=8, HOLD_N=3, mode=0. Send three valid samples of tone=1 -> led = 8'b1100_0000 one cycle after the third; led stays 0 after the first two.
- **Filter restart.** Send valid 2,2,5,5,5 -> led never shows code 2; led = 8'b0000_1100 after the last 5.
- **Bar mode.** mode=1 with `commit`=2 -> 8'b0111_1000; mode=1 with `commit`=7 -> 8'b0001_1111. Toggling mode changes led on the next cycle only.
- **On-pitch blink.** Use BLINK_HALF=4, blink_en=1, and commit code 4 -> locked = 1. led alternates 8'b0001_1000 / 0 every 4 cycles. Dropping blink_en gives a steady 8'b0001_1000.
- **Timeout and out-of-range.**
  - TIMEOUT_CYC=10: after a committed code with no further valid -> led = 0 and locked = 0 at cycle 11.
  - A valid sample on the timeout cycle prevents blanking.
  - With HOLD_N=1, code 9 on LED_W=8 -> led = 0.
- **Reset mid-blink.** rst during a committed on-pitch display -> led = 0 and locked = 0 on the next edge, with all state cleared.
